// File: rtl/bs_dev_pkg.sv
// bs_dev_pkg: shared definitions for the bus device endpoint.
//   ADDR_W        width of the destination-address field at the top of a packet
//   BCAST_DEFAULT default broadcast address
//   get_addr()    extracts the destination address from a packet of given width
//   sat_inc8()    8-bit saturating increment used by the drop counters
package bs_dev_pkg;

   localparam int unsigned      ADDR_W        = 8;
   localparam logic [ADDR_W-1:0] BCAST_DEFAULT = 8'hFF;

   // Packets are zero-extended to this width before address extraction so a
   // single helper serves any packet width up to MAX_PKT_W.
   localparam int unsigned MAX_PKT_W = 64;
   typedef logic [MAX_PKT_W-1:0] pkt_max_t;

   // Outcome of a push presented by the bus in the current cycle.
   typedef enum logic [1:0] {
      RX_IDLE,
      RX_ACCEPT,
      RX_DROP_ADDR,
      RX_DROP_OVF
   } rx_verdict_e;

   function automatic logic [ADDR_W-1:0] get_addr(input pkt_max_t pkt,
                                                  input int unsigned pkt_w);
      pkt_max_t shifted;
      shifted = pkt >> (pkt_w - ADDR_W);
      return shifted[ADDR_W-1:0];
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
      return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
   endfunction

endpackage

// File: rtl/bs_dev_fifo.sv
// bs_dev_fifo: synchronous first-word-fall-through FIFO.
//   clk, reset (sync, active-low) -- reset empties the FIFO and clears storage
//   wr, din   -- enqueue; accepted when not full, or when full with rd
//   rd        -- dequeue; ignored while empty
//   dout      -- current head (valid while empty==0)
//   full, empty -- derived from the registered occupancy count
// DEPTH need not be a power of two; pointers wrap explicitly at DEPTH-1.
module bs_dev_fifo
   import bs_dev_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [WIDTH-1:0] din,
   input  logic             rd,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_wr;
   logic             do_rd;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // A write while full succeeds only if a read frees the head slot in the
   // same cycle; the write lands in the slot after the current tail.
   assign do_wr = wr && (!full || rd);
   assign do_rd = rd && !empty;

   always_ff @(posedge clk) begin
      if (!reset) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (do_rd) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bs_dev_endpoint.sv
// bs_dev_endpoint: device-side endpoint of the bus FIFO protocol.
//   clk, reset (sync, active-low)
//   Bus side : pndng/pop/D_pop (TX head offered to the bus),
//              push/D_push (packets delivered by the bus)
//   Device   : tx_wr/tx_data/tx_full (TX enqueue),
//              rx_valid/rx_data/rx_rd (RX dequeue)
//   Status   : rx_drop_addr, rx_drop_ovf (8-bit saturating drop counters)
// Build option BS_DEV_PROMISC_EN adds input promisc, which lets every pushed
// packet through the address filter (overflow still applies).
module bs_dev_endpoint
   import bs_dev_pkg::*;
#(
   parameter int unsigned       tama_de_paquete = 16,
   parameter logic [ADDR_W-1:0] ID              = 8'h00,
   parameter int unsigned       tam_fifo        = 12,
   parameter logic [ADDR_W-1:0] broadcast       = BCAST_DEFAULT
) (
   input  logic                       clk,
   input  logic                       reset,
`ifdef BS_DEV_PROMISC_EN
   input  logic                       promisc,
`endif
   output logic                       pndng,
   input  logic                       pop,
   output logic [tama_de_paquete-1:0] D_pop,
   input  logic                       push,
   input  logic [tama_de_paquete-1:0] D_push,
   input  logic                       tx_wr,
   input  logic [tama_de_paquete-1:0] tx_data,
   output logic                       tx_full,
   output logic                       rx_valid,
   output logic [tama_de_paquete-1:0] rx_data,
   input  logic                       rx_rd,
   output logic [7:0]                 rx_drop_addr,
   output logic [7:0]                 rx_drop_ovf
);

   logic              tx_empty;
   logic              rx_empty;
   logic              rx_full;
   logic [ADDR_W-1:0] addr;
   logic              addr_ok;
   rx_verdict_e       verdict;

   bs_dev_fifo #(
      .WIDTH (tama_de_paquete),
      .DEPTH (tam_fifo)
   ) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (tx_wr),
      .din   (tx_data),
      .rd    (pop),
      .dout  (D_pop),
      .full  (tx_full),
      .empty (tx_empty)
   );

   assign pndng = !tx_empty;

   assign addr = get_addr(pkt_max_t'(D_push), tama_de_paquete);

`ifdef BS_DEV_PROMISC_EN
   assign addr_ok = promisc || (addr == ID) || (addr == broadcast);
`else
   assign addr_ok = (addr == ID) || (addr == broadcast);
`endif

   // Address filtering takes precedence over overflow: a misaddressed packet
   // is counted only as an address drop even when the RX FIFO is full.
   always_comb begin
      verdict = RX_IDLE;
      if (push) begin
         if (!addr_ok) begin
            verdict = RX_DROP_ADDR;
         end else if (rx_full && !rx_rd) begin
            verdict = RX_DROP_OVF;
         end else begin
            verdict = RX_ACCEPT;
         end
      end
   end

   bs_dev_fifo #(
      .WIDTH (tama_de_paquete),
      .DEPTH (tam_fifo)
   ) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (verdict == RX_ACCEPT),
      .din   (D_push),
      .rd    (rx_rd),
      .dout  (rx_data),
      .full  (rx_full),
      .empty (rx_empty)
   );

   assign rx_valid = !rx_empty;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_drop_addr <= '0;
         rx_drop_ovf  <= '0;
      end else begin
         if (verdict == RX_DROP_ADDR) begin
            rx_drop_addr <= sat_inc8(rx_drop_addr);
         end
         if (verdict == RX_DROP_OVF) begin
            rx_drop_ovf <= sat_inc8(rx_drop_ovf);
         end
      end
   end

endmodule

// File: doc/bs_dev_endpoint.md
Name: bs_dev_endpoint

Overview:
- Device-side endpoint of the bus generator/arbiter FIFO protocol: the counterpart to one `pndng/pop/D_pop/push/D_push` slice of the bus.
- TX path: the local device writes packets into a TX FIFO. The endpoint raises `pndng` and presents the head on `D_pop`; the bus consumes it with `pop`.
- RX path: the bus delivers packets with `push`/`D_push`. The endpoint filters on the destination address (own ID or broadcast) and queues accepted packets for the local device.
- One instance per device, replacing the behavioural FIFO model in the driver.

Parameters:
- tama_de_paquete, 16, packet width in bits; bits [tama_de_paquete-1 -: 8] are the destination address.
- ID, 0, this device's 8-bit address.
- tam_fifo, 12, depth of each FIFO in packets (any value ≥ 2, not necessarily a power of 2).
- broadcast, 8'hFF, broadcast address; a match is accepted by every endpoint.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- pndng  out  1  TX FIFO non-empty
- pop  in  1  bus consumes TX head this cycle
- D_pop  out  tama_de_paquete  TX head packet
- push  in  1  bus delivers a packet this cycle
- D_push  in  tama_de_paquete  delivered packet
- tx_wr  in  1  device writes a TX packet
- tx_data  in  tama_de_paquete  TX packet
- tx_full  out  1  TX FIFO full
- rx_valid  out  1  RX FIFO non-empty
- rx_data  out  tama_de_paquete  RX head packet
- rx_rd  in  1  device consumes RX head
- rx_drop_addr  out  8  saturating count of packets dropped for address mismatch
- rx_drop_ovf  out  8  saturating count of packets dropped because the RX FIFO was full

Behaviour:
- Reset: sampled on a clk edge with `reset`=0.
  - Both FIFOs are emptied and both counters cleared.
  - `pndng`=0, `tx_full`=0, `rx_valid`=0. `D_pop`=0 and `rx_data`=0 (storage and head cleared).
  - Reset mid-operation discards all queued packets. `pop`, `push`, `tx_wr` and `rx_rd` are ignored in the reset cycle.
- FIFOs are first-word-fall-through:
  - The head is visible on `D_pop`/`rx_data` in the cycle after the write that made the FIFO non-empty.
  - `pndng`/`rx_valid` are registered from the count and rise in that same cycle.
- TX write: `tx_wr` with `tx_full`=0 enqueues `tx_data`. `tx_wr` while full is ignored (packet lost, no error flag).
- TX pop: `pop` with `pndng`=1 dequeues the head; the next head appears the following cycle. `pop` while empty is ignored and `D_pop` is held.
- TX simultaneous ops:
  - `tx_wr` and `pop` in the same cycle when full: both succeed and the count is unchanged.
  - Same case when empty: the write succeeds, the pop is ignored.
- RX address match: on `push`, let `addr = D_push[tama_de_paquete-1 -: 8]`. The packet is accepted when `addr==ID` or `addr==broadcast`; otherwise it is dropped and `rx_drop_addr` increments.
- RX overflow: an accepted packet while the RX FIFO is full is dropped and `rx_drop_ovf` increments. Exception: when `rx_rd` is asserted in the same cycle, the read frees a slot and the push succeeds.
- RX read/write ordering: `rx_rd` while empty is ignored. `push` and `rx_rd` together when empty: the push is stored and the read is ignored.
- Counters saturate at 8'hFF; they do not wrap.
- Latency from `push` (accepted) to `rx_valid`: 1 cycle. From `tx_wr` to `pndng`: 1 cycle.
- Read/write pointers wrap modulo `tam_fifo`. The count is held in $clog2(tam_fifo+1) bits.
- Packet contents are never modified; the address field stays in the stored packet.

Optional Feature:
- Macro: BS_DEV_PROMISC_EN.
- Defined: adds input port `promisc` (1 bit). When `promisc`=1, every pushed packet passes the address filter, so `rx_drop_addr` does not increment; overflow rules still apply.
- Undefined: the port is absent and filtering is always ID/broadcast only.

Decomposition:
- Package bs_dev_pkg:
  - ADDR_W=8 and BCAST_DEFAULT=8'hFF.
  - Function `get_addr(pkt)` returning the top 8 bits.
  - Saturating-increment function for the 8-bit counters.
- Sub-module bs_dev_fifo: parameterised (width, depth) synchronous FWFT FIFO with wr/rd/full/empty/dout, reset synchronous active-low. It is instantiated twice (TX, RX).
- Address filter and counters live in the bs_dev_endpoint top.

Test Plan:
- Reset, then 3 `tx_wr` (16'h0101, 16'h0202, 16'h0303) -> `pndng`=1 one cycle after the first write; `D_pop`=16'h0101. After 3 pops, `D_pop` has stepped through 0202/0303 and `pndng`=0.
- 12 `tx_wr` -> `tx_full`=1. A 13th write is ignored. A simultaneous `tx_wr`+`pop` when full keeps the count at 12 and the last written packet is eventually popped.
- ID=0: push 16'h00AA, 16'hFFBB, 16'h05CC -> `rx_data` sequence 00AA then FFBB; `rx_drop_addr`=1.
- Fill RX with 12 packets for ID 0, push a 13th -> `rx_drop_ovf`=1. 13th push with `rx_rd` in the same cycle -> accepted, `rx_drop_ovf` unchanged.
- 300 misaddressed pushes -> `rx_drop_addr`=8'hFF. Assert `reset`=0 for one cycle with data queued -> `rx_valid`=0, `pndng`=0, counters=0.
- With BS_DEV_PROMISC_EN and `promisc`=1: push 16'h05CC -> accepted and `rx_drop_addr` stays 0. With `promisc`=0 the same push is dropped.
